// File: rtl/e_ppn_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : e_ppn_addsub_arbiter
// Description : Three-requester round-robin front end for a shared add/sub
//               unit. Latches the winner's operands, starts the unit, waits
//               for done (with timeout), picks up the late sign and
//               broadcasts the result with a one-hot done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module e_ppn_addsub_arbiter #(
   parameter int WIDTH   = 256,
   parameter int TIMEOUT = 31
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [2:0]           req_i,
   input  logic [3*WIDTH-1:0]   a_i,
   input  logic [3*WIDTH-1:0]   b_i,
   input  logic [2:0]           sel_i,
   input  logic [2:0]           sign_a_i,
   input  logic [2:0]           sign_b_i,
   output logic [2:0]           gnt_o,
   output logic [WIDTH-1:0]     res_data_o,
   output logic                 res_c_o,
   output logic                 res_sign_o,
   output logic                 res_err_o,
   output logic [2:0]           res_done_o,
   output logic                 busy_o,
   output logic                 au_start_o,
   output logic [WIDTH-1:0]     au_a_o,
   output logic [WIDTH-1:0]     au_b_o,
   output logic                 au_sel_o,
   output logic                 au_sign_a_o,
   output logic                 au_sign_b_o,
   input  logic [WIDTH-1:0]     au_data_i,
   input  logic                 au_c_i,
   input  logic                 au_sign_i,
   input  logic                 au_done_i
);

   localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_WAIT  = 3'd2,
      S_SIGN  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   state_t           r_state;
   logic [1:0]       r_last;
   logic [1:0]       r_win;
   logic [7:0]       r_cnt;
   logic [WIDTH-1:0] r_cap_data;
   logic             r_cap_c;

   logic [2:0]       r_gnt;
   logic             r_start;
   logic [WIDTH-1:0] r_au_a;
   logic [WIDTH-1:0] r_au_b;
   logic             r_au_sel;
   logic             r_au_sign_a;
   logic             r_au_sign_b;
   logic [WIDTH-1:0] r_res_data;
   logic             r_res_c;
   logic             r_res_sign;
   logic             r_res_err;
   logic [2:0]       r_res_done;

   logic [1:0]       w_win;

   // Round-robin pick: first active requester after the last winner.
   always_comb begin
      w_win = 2'd0;
      case (r_last)
         2'd0: begin
            if (req_i[1])      w_win = 2'd1;
            else if (req_i[2]) w_win = 2'd2;
            else               w_win = 2'd0;
         end
         2'd1: begin
            if (req_i[2])      w_win = 2'd2;
            else if (req_i[0]) w_win = 2'd0;
            else               w_win = 2'd1;
         end
         default: begin
            if (req_i[0])      w_win = 2'd0;
            else if (req_i[1]) w_win = 2'd1;
            else               w_win = 2'd2;
         end
      endcase
   end

   // Operation sequencer: grant, start, wait/timeout, late sign, respond.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_last      <= 2'd2;
         r_win       <= 2'd0;
         r_cnt       <= 8'd0;
         r_cap_data  <= '0;
         r_cap_c     <= 1'b0;
         r_gnt       <= 3'b000;
         r_start     <= 1'b0;
         r_au_a      <= '0;
         r_au_b      <= '0;
         r_au_sel    <= 1'b0;
         r_au_sign_a <= 1'b0;
         r_au_sign_b <= 1'b0;
         r_res_data  <= '0;
         r_res_c     <= 1'b0;
         r_res_sign  <= 1'b0;
         r_res_err   <= 1'b0;
         r_res_done  <= 3'b000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (|req_i) begin
                  r_win       <= w_win;
                  r_au_a      <= a_i[int'(w_win)*WIDTH +: WIDTH];
                  r_au_b      <= b_i[int'(w_win)*WIDTH +: WIDTH];
                  r_au_sel    <= sel_i[w_win];
                  r_au_sign_a <= sign_a_i[w_win];
                  r_au_sign_b <= sign_b_i[w_win];
                  r_gnt       <= 3'b001 << w_win;
                  r_start     <= 1'b1;
                  r_state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_gnt   <= 3'b000;
               r_start <= 1'b0;
               r_cnt   <= 8'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               // Done takes priority over a timeout landing on the same cycle.
               if (au_done_i) begin
                  r_cap_data <= au_data_i;
                  r_cap_c    <= au_c_i;
                  r_state    <= S_SIGN;
               end else if (r_cnt == C_TIMEOUT) begin
                  r_cap_data <= '0;
                  r_cap_c    <= 1'b0;
                  r_res_data <= '0;
                  r_res_c    <= 1'b0;
                  r_res_sign <= 1'b0;
                  r_res_err  <= 1'b1;
                  r_res_done <= 3'b001 << r_win;
                  r_state    <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_SIGN: begin
               // The unit's sign settles one cycle after its done strobe.
               r_res_data <= r_cap_data;
               r_res_c    <= r_cap_c;
               r_res_sign <= au_sign_i;
               r_res_err  <= 1'b0;
               r_res_done <= 3'b001 << r_win;
               r_state    <= S_RESP;
            end
            S_RESP: begin
               r_res_done <= 3'b000;
               r_last     <= r_win;
               r_state    <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_o      = (r_state != S_IDLE);
   assign gnt_o       = r_gnt;
   assign au_start_o  = r_start;
   assign au_a_o      = r_au_a;
   assign au_b_o      = r_au_b;
   assign au_sel_o    = r_au_sel;
   assign au_sign_a_o = r_au_sign_a;
   assign au_sign_b_o = r_au_sign_b;
   assign res_data_o  = r_res_data;
   assign res_c_o     = r_res_c;
   assign res_sign_o  = r_res_sign;
   assign res_err_o   = r_res_err;
   assign res_done_o  = r_res_done;

endmodule
`default_nettype wire

// File: tb/tb_e_ppn_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_e_ppn_addsub_arbiter
// Description : Scenario bench for e_ppn_addsub_arbiter with a behavioural
//               add/sub unit and grant/result scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_e_ppn_addsub_arbiter;

   localparam int WIDTH   = 256;
   localparam int TIMEOUT = 31;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [2:0]           req_i;
   logic [3*WIDTH-1:0]   a_i, b_i;
   logic [2:0]           sel_i, sign_a_i, sign_b_i;
   logic [2:0]           gnt_o;
   logic [WIDTH-1:0]     res_data_o;
   logic                 res_c_o, res_sign_o, res_err_o;
   logic [2:0]           res_done_o;
   logic                 busy_o, au_start_o;
   logic [WIDTH-1:0]     au_a_o, au_b_o;
   logic                 au_sel_o, au_sign_a_o, au_sign_b_o;
   logic [WIDTH-1:0]     au_data_i;
   logic                 au_c_i, au_sign_i, au_done_i;

   typedef struct packed {
      logic [2:0]       done;
      logic [WIDTH-1:0] data;
      logic             c;
      logic             sign;
      logic             err;
   } res_t;

   res_t       exp_res[$];
   logic [2:0] exp_gnt[$];

   int errors = 0, checks = 0;
   int cyc = 0, n_gnt = 0, n_res = 0, n_start = 0;
   int t_gnt = 0, t_gnt_prev = 0, t_res = 0;

   // unit model state
   int               m_delay = 0;
   int               m_phase = 0;
   int               m_cnt = 0;
   logic             spur = 1'b0;
   logic [WIDTH-1:0] m_a, m_b;
   logic             m_sel, m_sa, m_sb;
   logic [WIDTH+1:0] m_r;

   e_ppn_addsub_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .a_i(a_i), .b_i(b_i),
      .sel_i(sel_i), .sign_a_i(sign_a_i), .sign_b_i(sign_b_i),
      .gnt_o(gnt_o), .res_data_o(res_data_o), .res_c_o(res_c_o),
      .res_sign_o(res_sign_o), .res_err_o(res_err_o), .res_done_o(res_done_o),
      .busy_o(busy_o), .au_start_o(au_start_o), .au_a_o(au_a_o), .au_b_o(au_b_o),
      .au_sel_o(au_sel_o), .au_sign_a_o(au_sign_a_o), .au_sign_b_o(au_sign_b_o),
      .au_data_i(au_data_i), .au_c_i(au_c_i), .au_sign_i(au_sign_i),
      .au_done_i(au_done_i)
   );

   always #5 clk = ~clk;

   // Sign-magnitude add/sub; returns {sign, carry, magnitude}.
   function automatic logic [WIDTH+1:0] unit_fn(input logic [WIDTH-1:0] a, b,
                                                input logic sel, sa, sb);
      logic [WIDTH:0] s;
      if ((sel ^ sa ^ sb) == 1'b0) begin
         s = {1'b0, a} + {1'b0, b};
         return {sa, s[WIDTH], s[WIDTH-1:0]};
      end else if (a >= b) begin
         return {sa, 1'b0, a - b};
      end else begin
         return {~sa, 1'b0, b - a};
      end
   endfunction

   function automatic logic [WIDTH-1:0] rand_w();
      logic [WIDTH-1:0] v;
      for (int i = 0; i < WIDTH/32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // mode 0: normal result expected, 1: timeout result, 2: grant only
   task automatic push_op(input int k, input logic [WIDTH-1:0] a, b,
                          input logic sel, sa, sb, input int mode);
      logic [WIDTH+1:0] r;
      res_t e;
      a_i[k*WIDTH +: WIDTH] = a;
      b_i[k*WIDTH +: WIDTH] = b;
      sel_i[k] = sel; sign_a_i[k] = sa; sign_b_i[k] = sb;
      r = unit_fn(a, b, sel, sa, sb);
      e.done = 3'b001 << k;
      e.data = (mode == 1) ? '0 : r[WIDTH-1:0];
      e.c    = (mode == 1) ? 1'b0 : r[WIDTH];
      e.sign = (mode == 1) ? 1'b0 : r[WIDTH+1];
      e.err  = (mode == 1);
      exp_gnt.push_back(3'b001 << k);
      if (mode != 2) exp_res.push_back(e);
   endtask

   // One clock: sample at the falling edge, score outputs, advance the unit.
   task automatic tick();
      logic [2:0] g;
      res_t e;
      @(negedge clk);
      cyc++;
      if (gnt_o !== 3'b000) begin
         checks++;
         if (exp_gnt.size() == 0) begin
            errors++;
            $display("FAIL gnt_unexpected: gnt_o=%b, required none", gnt_o);
         end else begin
            g = exp_gnt.pop_front();
            if (gnt_o !== g) begin
               errors++;
               $display("FAIL gnt_order: gnt_o=%b, required %b", gnt_o, g);
            end
         end
         checks++;
         if (au_start_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL issue_flags: start=%b busy=%b, required 1 1", au_start_o, busy_o);
         end
         t_gnt_prev = t_gnt;
         t_gnt = cyc;
         n_gnt++;
      end else if (au_start_o !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL start_without_gnt: au_start_o=%b, required 0", au_start_o);
      end
      if (au_start_o === 1'b1) n_start++;
      if (res_done_o !== 3'b000) begin
         checks++;
         if (exp_res.size() == 0) begin
            errors++;
            $display("FAIL res_unexpected: res_done_o=%b, required none", res_done_o);
         end else begin
            e = exp_res.pop_front();
            if ({res_done_o, res_data_o, res_c_o, res_sign_o, res_err_o} !== e) begin
               errors++;
               $display("FAIL result: got done=%b c=%b sign=%b err=%b data=%h, required done=%b c=%b sign=%b err=%b data=%h",
                        res_done_o, res_c_o, res_sign_o, res_err_o, res_data_o,
                        e.done, e.c, e.sign, e.err, e.data);
            end
         end
         t_res = cyc;
         n_res++;
      end
      // behavioural add/sub unit
      au_done_i = 1'b0;
      if (reset) begin
         m_phase = 0;
      end else begin
         case (m_phase)
            0: begin
               if (spur) begin
                  au_done_i = 1'b1;
                  au_data_i = {8{32'hdeadbeef}};
                  au_c_i    = 1'b1;
                  spur      = 1'b0;
               end
               if (au_start_o === 1'b1) begin
                  m_a = au_a_o; m_b = au_b_o;
                  m_sel = au_sel_o; m_sa = au_sign_a_o; m_sb = au_sign_b_o;
                  m_r = unit_fn(m_a, m_b, m_sel, m_sa, m_sb);
                  if (m_delay >= 0) begin
                     m_cnt = m_delay + 1;
                     m_phase = 1;
                  end
               end
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  au_done_i = 1'b1;
                  au_data_i = m_r[WIDTH-1:0];
                  au_c_i    = m_r[WIDTH];
                  au_sign_i = ~m_r[WIDTH+1];
                  m_phase   = 2;
                  checks++;
                  if ({au_a_o, au_b_o, au_sel_o, au_sign_a_o, au_sign_b_o} !== {m_a, m_b, m_sel, m_sa, m_sb}) begin
                     errors++;
                     $display("FAIL au_hold_wait: a=%h sel=%b, required a=%h sel=%b", au_a_o, au_sel_o, m_a, m_sel);
                  end
               end
            end
            2: begin
               au_data_i = ~au_data_i;
               au_c_i    = ~au_c_i;
               au_sign_i = m_r[WIDTH+1];
               m_phase   = 0;
               checks++;
               if ({au_a_o, au_b_o, au_sel_o, au_sign_a_o, au_sign_b_o} !== {m_a, m_b, m_sel, m_sa, m_sb}) begin
                  errors++;
                  $display("FAIL au_hold_sign: a=%h sel=%b, required a=%h sel=%b", au_a_o, au_sel_o, m_a, m_sel);
               end
            end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic wait_gnt(input int target, input int budget, input string name);
      for (int i = 0; i < budget && n_gnt < target; i++) tick();
      checks++;
      if (n_gnt < target) begin
         errors++;
         $display("FAIL %s: grants=%0d, required %0d within %0d cycles", name, n_gnt, target, budget);
      end
   endtask

   task automatic wait_res(input int target, input int budget, input string name);
      for (int i = 0; i < budget && n_res < target; i++) tick();
      checks++;
      if (n_res < target) begin
         errors++;
         $display("FAIL %s: results=%0d, required %0d within %0d cycles", name, n_res, target, budget);
      end
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({gnt_o, res_done_o, busy_o, au_start_o} !== 8'd0) begin
         errors++;
         $display("FAIL %s_ctrl: gnt=%b done=%b busy=%b start=%b, required all 0", name, gnt_o, res_done_o, busy_o, au_start_o);
      end
      checks++;
      if ({res_data_o, res_c_o, res_sign_o, res_err_o} !== '0) begin
         errors++;
         $display("FAIL %s_res: data=%h c=%b sign=%b err=%b, required 0", name, res_data_o, res_c_o, res_sign_o, res_err_o);
      end
      checks++;
      if ({au_a_o, au_b_o, au_sel_o, au_sign_a_o, au_sign_b_o} !== '0) begin
         errors++;
         $display("FAIL %s_au: a=%h b=%h sel=%b, required 0", name, au_a_o, au_b_o, au_sel_o);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single_add();
      int bg = n_gnt, br = n_res, bs = n_start;
      m_delay = 11;
      push_op(0, WIDTH'(5), WIDTH'(3), 1'b0, 1'b0, 1'b0, 0);
      req_i = 3'b001;
      wait_gnt(bg + 1, 10, "add_grant");
      req_i = 3'b000;
      a_i[0 +: WIDTH] = '1; b_i[0 +: WIDTH] = '1; sel_i = 3'b111;
      wait_res(br + 1, 40, "add_result");
      checks++;
      if (t_res - t_gnt != 14) begin
         errors++;
         $display("FAIL add_latency: %0d cycles, required 14", t_res - t_gnt);
      end
      checks++;
      if (n_start - bs != 1) begin
         errors++;
         $display("FAIL add_start_pulses: %0d, required 1", n_start - bs);
      end
      repeat (3) tick();
      checks++;
      if ({res_data_o, res_c_o, res_err_o} !== {WIDTH'(8), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL add_hold: data=%0d c=%b err=%b, required 8 0 0", res_data_o, res_c_o, res_err_o);
      end
   endtask

   task automatic test_sub_sign();
      int bg = n_gnt, br = n_res;
      m_delay = 4;
      push_op(1, WIDTH'(3), WIDTH'(5), 1'b1, 1'b0, 1'b0, 0);
      req_i = 3'b010;
      wait_gnt(bg + 1, 10, "sub_grant");
      req_i = 3'b000;
      wait_res(br + 1, 40, "sub_result");
      checks++;
      if (res_sign_o !== 1'b1 || res_data_o !== WIDTH'(2)) begin
         errors++;
         $display("FAIL sub_sign: sign=%b data=%0d, required 1 2", res_sign_o, res_data_o);
      end
      checks++;
      if (t_res - t_gnt != 7) begin
         errors++;
         $display("FAIL sub_latency: %0d cycles, required 7", t_res - t_gnt);
      end
   endtask

   task automatic test_spurious_done();
      int br = n_res;
      spur = 1'b1;
      repeat (3) tick();
      checks++;
      if (busy_o !== 1'b0 || n_res != br) begin
         errors++;
         $display("FAIL spurious_done: busy=%b results=%0d, required 0 %0d", busy_o, n_res, br);
      end
      checks++;
      if (res_data_o !== WIDTH'(2) || res_sign_o !== 1'b1) begin
         errors++;
         $display("FAIL spurious_hold: data=%0d sign=%b, required 2 1", res_data_o, res_sign_o);
      end
   endtask

   task automatic test_contention();
      logic [WIDTH-1:0] ca[3], cb[3];
      logic [2:0] cs, csa, csb;
      int bg, br;
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      bg = n_gnt; br = n_res;
      m_delay = 3;
      cs = 3'($urandom); csa = 3'($urandom); csb = 3'($urandom);
      for (int k = 0; k < 3; k++) begin
         ca[k] = rand_w();
         cb[k] = rand_w();
      end
      for (int n = 0; n < 4; n++)
         push_op(n % 3, ca[n % 3], cb[n % 3], cs[n % 3], csa[n % 3], csb[n % 3], 0);
      req_i = 3'b111;
      wait_gnt(bg + 4, 60, "rr_grants");
      req_i = 3'b000;
      checks++;
      if (t_gnt - t_gnt_prev != 8) begin
         errors++;
         $display("FAIL rr_period: %0d cycles between grants, required 8", t_gnt - t_gnt_prev);
      end
      wait_res(br + 4, 40, "rr_results");
   endtask

   task automatic test_timeout();
      int bg = n_gnt, br = n_res;
      m_delay = -1;
      push_op(2, rand_w(), rand_w(), 1'b0, 1'b0, 1'b0, 1);
      req_i = 3'b100;
      wait_gnt(bg + 1, 10, "timeout_grant");
      req_i = 3'b000;
      wait_res(br + 1, 60, "timeout_result");
      checks++;
      if (t_res - t_gnt != 33) begin
         errors++;
         $display("FAIL timeout_latency: %0d cycles after issue, required 33", t_res - t_gnt);
      end
   endtask

   task automatic test_done_on_timeout();
      int bg = n_gnt, br = n_res;
      m_delay = TIMEOUT;
      push_op(0, rand_w(), rand_w(), 1'b1, 1'b1, 1'b0, 0);
      req_i = 3'b001;
      wait_gnt(bg + 1, 10, "edge_grant");
      req_i = 3'b000;
      wait_res(br + 1, 60, "edge_result");
      checks++;
      if (t_res - t_gnt != 34) begin
         errors++;
         $display("FAIL edge_latency: %0d cycles, required 34", t_res - t_gnt);
      end
      checks++;
      if (res_err_o !== 1'b0 || res_sign_o !== 1'b1) begin
         errors++;
         $display("FAIL edge_flags: err=%b sign=%b, required 0 1", res_err_o, res_sign_o);
      end
   endtask

   task automatic test_reset_mid_op();
      int bg = n_gnt, br = n_res;
      m_delay = -1;
      push_op(2, rand_w(), rand_w(), 1'b0, 1'b0, 1'b0, 2);
      req_i = 3'b100;
      wait_gnt(bg + 1, 10, "abort_grant");
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_all_zero("abort");
      m_delay = 2;
      push_op(2, rand_w(), rand_w(), 1'b1, 1'b0, 1'b1, 0);
      wait_gnt(bg + 2, 10, "rearb_grant");
      req_i = 3'b000;
      wait_res(br + 1, 40, "rearb_result");
      repeat (4) tick();
      checks++;
      if (n_res != br + 1) begin
         errors++;
         $display("FAIL abort_results: %0d results, required %0d", n_res - br, 1);
      end
   endtask

   initial begin
      reset = 1'b1; req_i = 3'b000; a_i = '0; b_i = '0;
      sel_i = 3'b000; sign_a_i = 3'b000; sign_b_i = 3'b000;
      au_data_i = '0; au_c_i = 1'b0; au_sign_i = 1'b0; au_done_i = 1'b0;
      test_reset();
      test_single_add();
      test_sub_sign();
      test_spurious_done();
      test_contention();
      test_timeout();
      test_done_on_timeout();
      test_reset_mid_op();
      checks++;
      if (exp_gnt.size() != 0 || exp_res.size() != 0) begin
         errors++;
         $display("FAIL leftover: grants=%0d results=%0d pending, required 0 0", exp_gnt.size(), exp_res.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
